b_traceback_322: RTL and testbench
==================================

// Module: b_traceback_322
// PURPOSE
//  Traceback unit for the (3,2,2) Viterbi decoder (8 states, 2 info bits per trellis step).
//  - Stores per-step survivor decisions from the ACS array in a circular survivor memory.
//  - Every TB_LEN steps, traces back 2*TB_LEN columns from the minimum-metric state,
//    which the traceback decision unit supplies on best_state.
//  - Emits TB_LEN decoded 2-bit symbols in chronological order.
// PARAMETERS
//  TB_LEN  12  decode block / merge depth in trellis steps; legal range >= 2
//  AW      5   survivor memory address width; must satisfy 2**AW >= 2*TB_LEN
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high reset
//  in_valid    in   1   surv holds a new trellis column
//  in_ready    out  1   column accepted on clk edge when in_valid && in_ready
//  surv        in   16  survivor decisions; surv[2s+1:2s] = discarded input bits d of state s's winning predecessor
//  best_state  in   3   minimum-metric state from the traceback decision unit; must reflect all accepted columns
//  out_valid   out  1   out_bits valid this cycle; no backpressure
//  out_bits    out  2   decoded info bits {u1,u0}, oldest first
// BEHAVIOUR
//  Trellis convention: next = {prev[0], u[1:0]}; predecessor of s with decision d = {d, s[2]}.
//  Decoded bits of a column = state-after-column[1:0].
//  Reset values: state FILL, wr_ptr=0, fill_cnt=0, emit_cnt=0, out_valid=0, out_bits=2'b00.
//  in_ready = (state==FILL), combinational from the state register; it is 1 out of reset.
//  FILL
//   - On each accept: mem[wr_ptr] <= surv; wr_ptr <= (wr_ptr==2*TB_LEN-1) ? 0 : wr_ptr+1.
//   - Trigger: first trace after 2*TB_LEN accepted columns; thereafter after every TB_LEN further accepts.
//   - On the triggering accept, the next state is TRACE.
//  TRACE (exactly 2*TB_LEN cycles, k=0..2*TB_LEN-1)
//   - Cycle k=0: tb_state <= best_state, sampled that cycle; rd starts at the newest column (wr_ptr-1, mod 2*TB_LEN).
//   - Each cycle: d = mem[rd][2*tb_state+:2]. If k >= TB_LEN, rev_buf[k-TB_LEN] <= tb_state[1:0].
//     Then tb_state <= {d, tb_state[2]}; rd <= rd-1 (wrap to 2*TB_LEN-1).
//   - Steps k < TB_LEN are merge only; nothing is stored.
//   - in_ready=0 throughout. in_valid during TRACE is ignored; upstream holds the column.
//   - After cycle k=2*TB_LEN-1: state -> FILL and emission starts.
//  EMIT (runs concurrently with FILL)
//   - out_valid=1 for TB_LEN consecutive cycles immediately following the last TRACE cycle.
//   - Cycle j: out_bits = rev_buf[TB_LEN-1-j], oldest decoded step first.
//   - out_bits holds its last value while out_valid=0.
//   - The next trace needs TB_LEN accepts (>= TB_LEN cycles), so rev_buf is never overwritten mid-emit.
//  Latency: triggering column accepted at edge e -> TRACE occupies cycles e+1..e+2*TB_LEN ->
//   out_valid high cycles e+2*TB_LEN+1 .. e+3*TB_LEN.
//  Boundary conditions
//   - wr_ptr and rd wrap modulo 2*TB_LEN, not modulo 2**AW.
//   - fill_cnt saturates once the initial 2*TB_LEN fill is complete.
//   - in_valid low for any duration in FILL: pointers hold, no trace starts.
//  Reset at any time: returns to FILL with empty memory.
//   - Aborts any trace in progress.
//   - Drops out_valid on the next edge; pending symbols are discarded.
//   - The next trace again requires 2*TB_LEN fresh columns.
// TESTING
//  T1 all-zero: TB_LEN=12, surv=16'h0, best_state=0, 24 back-to-back accepts ->
//     in_ready low exactly 24 cycles; then 12 out_valid cycles, out_bits=00.
//  T2 known path: u = 01,10,11,00 repeating; surv built from the true state path,
//     off-path entries random; best_state = true final state ->
//     out_bits = u[0..11] in order; later blocks give u[12..23], ...
//  T3 stall: hold in_valid=1 with a distinct surv through TRACE ->
//     no accept while in_ready=0; the held column is written on the first FILL cycle;
//     the next trace fires after exactly 12 more accepts.
//  T4 wrap: 6 consecutive blocks of T2 with random in_valid gaps ->
//     every symbol correct across wr_ptr/rd wrap at 23->0; output gaps only between blocks.
//  T5 reset mid-trace: assert reset at TRACE cycle k=5 ->
//     in_ready=1 and out_valid=0 after reset; first out_valid only after 24 new accepts + 24 cycles.
//  T6 wrong start state: T2 with best_state forced to (true^3'b101) ->
//     out_bits still correct, because the 12 merge steps reconverge on an all-on-path survivor memory.

Source files
------------

// File: rtl/b_traceback_322.sv
// Traceback unit for the (3,2,2) Viterbi decoder: 8 states, 2 info bits per step.
// Survivor columns are stored in a circular memory of 2*TB_LEN entries.
// Every TB_LEN accepted columns (after an initial 2*TB_LEN fill), the unit traces
// back 2*TB_LEN columns from best_state. The first TB_LEN steps only merge onto
// the survivor path. The last TB_LEN steps are captured and replayed oldest-first.
module b_traceback_322 #(
  parameter int TB_LEN = 12,
  parameter int AW     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] surv,
  input  logic [2:0]  best_state,
  output logic        out_valid,
  output logic [1:0]  out_bits
);

  localparam int DEPTH = 2 * TB_LEN;
  localparam int MW    = $clog2(DEPTH);
  localparam int RW    = $clog2(TB_LEN);

  localparam logic [AW-1:0] ZERO_A    = AW'(0);
  localparam logic [AW-1:0] ONE_A     = AW'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_K    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] BLK_LAST  = AW'(TB_LEN - 1);
  localparam logic [AW-1:0] TB_LEN_A  = AW'(TB_LEN);
  localparam logic [AW:0]   ONE_F     = (AW+1)'(1);
  localparam logic [AW:0]   FILL_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_TRACE = 1'b1
  } state_t;

  // Circular pointer step forward, wrapping at the memory depth rather than 2**AW.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    logic [AW-1:0] r;
    if (p == LAST_ADDR) begin
      r = ZERO_A;
    end else begin
      r = p + ONE_A;
    end
    return r;
  endfunction

  // Circular pointer step backward, wrapping at the memory depth rather than 2**AW.
  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    logic [AW-1:0] r;
    if (p == ZERO_A) begin
      r = LAST_ADDR;
    end else begin
      r = p - ONE_A;
    end
    return r;
  endfunction

  state_t          state_r;
  state_t          state_s;

  logic [15:0]     mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW:0]     fill_cnt_r;
  logic [AW-1:0]   blk_cnt_r;

  logic [AW-1:0]   rd_r;
  logic [AW-1:0]   k_r;
  logic [2:0]      tb_state_r;
  logic [1:0]      rev_buf_r [TB_LEN];

  logic [AW-1:0]   emit_cnt_r;
  logic            out_valid_r;
  logic [1:0]      out_bits_r;

  logic            accept_s;
  logic            trigger_s;
  logic            in_trace_s;
  logic            last_trace_s;
  logic            store_s;
  logic [2:0]      cur_state_s;
  logic [15:0]     col_s;
  logic [1:0]      dec_s;
  logic [2:0]      pred_s;
  logic [RW-1:0]   rev_wr_idx_s;
  logic [RW-1:0]   rev_rd_idx_s;

  assign out_valid = out_valid_r;
  assign out_bits  = out_bits_r;

  // Accept/trigger decode: first trace after a full 2*TB_LEN fill, then every TB_LEN accepts.
  always_comb begin
    accept_s  = 1'b0;
    trigger_s = 1'b0;
    if (state_r == ST_FILL) begin
      accept_s = in_valid;
    end else begin
      accept_s = 1'b0;
    end
    if (accept_s) begin
      if (fill_cnt_r == FILL_LAST) begin
        trigger_s = 1'b1;
      end else if ((fill_cnt_r == FILL_FULL) && (blk_cnt_r == BLK_LAST)) begin
        trigger_s = 1'b1;
      end else begin
        trigger_s = 1'b0;
      end
    end else begin
      trigger_s = 1'b0;
    end
  end

  // Next-state logic and the ready handshake, which is high only while filling.
  always_comb begin
    state_s  = state_r;
    in_ready = 1'b0;
    case (state_r)
      ST_FILL: begin
        in_ready = 1'b1;
        if (trigger_s) begin
          state_s = ST_TRACE;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_TRACE: begin
        in_ready = 1'b0;
        if (k_r == LAST_K) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_TRACE;
        end
      end
      default: begin
        in_ready = 1'b0;
        state_s  = ST_FILL;
      end
    endcase
  end

  // Traceback datapath: on the first step the start state comes straight from best_state.
  always_comb begin
    in_trace_s   = (state_r == ST_TRACE);
    last_trace_s = 1'b0;
    store_s      = 1'b0;
    cur_state_s  = tb_state_r;
    if (k_r == ZERO_A) begin
      cur_state_s = best_state;
    end else begin
      cur_state_s = tb_state_r;
    end
    col_s        = mem_r[MW'(rd_r)];
    dec_s        = col_s[{cur_state_s, 1'b0} +: 2];
    pred_s       = {dec_s, cur_state_s[2]};
    rev_wr_idx_s = RW'(k_r - TB_LEN_A);
    rev_rd_idx_s = RW'(BLK_LAST - emit_cnt_r);
    if (in_trace_s) begin
      last_trace_s = (k_r == LAST_K);
      store_s      = (k_r >= TB_LEN_A);
    end else begin
      last_trace_s = 1'b0;
      store_s      = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Survivor memory write side: column store, write pointer, fill and block counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= ZERO_A;
      fill_cnt_r <= (AW+1)'(0);
      blk_cnt_r  <= ZERO_A;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (accept_s) begin
      mem_r[MW'(wr_ptr_r)] <= surv;
      wr_ptr_r             <= ptr_inc(wr_ptr_r);
      if (fill_cnt_r != FILL_FULL) begin
        fill_cnt_r <= fill_cnt_r + ONE_F;
        blk_cnt_r  <= ZERO_A;
      end else if (blk_cnt_r == BLK_LAST) begin
        blk_cnt_r <= ZERO_A;
      end else begin
        blk_cnt_r <= blk_cnt_r + ONE_A;
      end
    end
  end

  // Trace walker: follows predecessors backward and captures the older half of the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_r        <= ZERO_A;
      rd_r       <= ZERO_A;
      tb_state_r <= 3'b000;
      for (int i = 0; i < TB_LEN; i++) begin
        rev_buf_r[i] <= 2'b00;
      end
    end else if (in_trace_s) begin
      if (store_s) begin
        rev_buf_r[rev_wr_idx_s] <= cur_state_s[1:0];
      end
      tb_state_r <= pred_s;
      rd_r       <= ptr_dec(rd_r);
      if (k_r == LAST_K) begin
        k_r <= ZERO_A;
      end else begin
        k_r <= k_r + ONE_A;
      end
    end else if (trigger_s) begin
      // The triggering column lands at the current write pointer; start there.
      rd_r <= wr_ptr_r;
      k_r  <= ZERO_A;
    end
  end

  // Emitter: replays the captured block oldest-first; the first symbol bypasses rev_buf.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      emit_cnt_r  <= ZERO_A;
      out_valid_r <= 1'b0;
      out_bits_r  <= 2'b00;
    end else if (last_trace_s) begin
      out_valid_r <= 1'b1;
      out_bits_r  <= cur_state_s[1:0];
      emit_cnt_r  <= ONE_A;
    end else if (out_valid_r) begin
      if (emit_cnt_r == TB_LEN_A) begin
        out_valid_r <= 1'b0;
        emit_cnt_r  <= ZERO_A;
      end else begin
        out_bits_r <= rev_buf_r[rev_rd_idx_s];
        emit_cnt_r <= emit_cnt_r + ONE_A;
      end
    end
  end

endmodule

// File: tb/tb_b_traceback_322.sv
// Directed bench for b_traceback_322: builds survivor columns from a known
// encoder path and checks every decoded symbol, latency and handshake timing.
module tb_b_traceback_322;

  localparam int TB_LEN = 12;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] surv;
  logic [2:0]  best_state;
  logic        out_valid;
  logic [1:0]  out_bits;

  int          total;
  int          bad;
  int          n_emit;
  int          run_len;
  int          wr_idx;
  int          rd_idx;
  logic [1:0]  exp_arr [512];
  logic [2:0]  enc_st;

  b_traceback_322 #(.TB_LEN(TB_LEN), .AW(5)) dut (
    .clk        (clk),
    .reset      (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .surv       (surv),
    .best_state (best_state),
    .out_valid  (out_valid),
    .out_bits   (out_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // One clock: advance to 1 time unit after the rising edge, then score any emitted symbol.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      rd_idx  = wr_idx;
      run_len = 0;
    end else if (out_valid) begin
      run_len++;
      n_emit++;
      if (rd_idx < wr_idx) begin
        check_val("sym", 32'(out_bits), 32'(exp_arr[9'(rd_idx)]));
        rd_idx++;
      end else begin
        check_val("sym_extra", 32'(out_valid), 32'(0));
      end
    end else if (run_len != 0) begin
      check_val("run_len", 32'(run_len), 32'(TB_LEN));
      run_len = 0;
    end
  endtask

  function automatic logic [1:0] pat(input int i);
    case (i % 4)
      0:       return 2'b01;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Offer one column for encoder input u; waits counts cycles spent with in_ready low.
  task automatic push_col(input logic [1:0] u, input bit all_on, input bit bad_best,
                          input int gap, output int waits);
    logic [2:0]  nxt;
    logic [15:0] sv;
    bit          acc;
    nxt = {enc_st[0], u};
    for (int s = 0; s < 8; s++) begin
      if (all_on || (s == int'(nxt))) sv[2*s +: 2] = enc_st[2:1];
      else                             sv[2*s +: 2] = 2'($urandom_range(0, 3));
    end
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    surv     = sv;
    waits    = 0;
    acc      = 1'b0;
    while (!acc) begin
      acc = in_ready;
      tick();
      if (!acc) begin
        waits++;
        if (waits > 200) begin
          check_val("accept_timeout", 32'(waits), 32'(0));
          acc = 1'b1;
        end
      end
    end
    enc_st     = nxt;
    best_state = bad_best ? (nxt ^ 3'b101) : nxt;
    exp_arr[9'(wr_idx)] = u;
    wr_idx++;
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst        = 1'b0;
    enc_st     = 3'b000;
    best_state = 3'b000;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int w;
    int lo;
    int ov;
    int n0;
    total = 0; bad = 0; n_emit = 0; run_len = 0; wr_idx = 0; rd_idx = 0;
    rst = 1'b1; in_valid = 1'b0; surv = 16'h0000; best_state = 3'b000; enc_st = 3'b000;
    tick();
    tick();
    check_val("rst_in_ready", 32'(in_ready), 32'(1));
    check_val("rst_out_valid", 32'(out_valid), 32'(0));
    check_val("rst_out_bits", 32'(out_bits), 32'(0));
    rst = 1'b0;
    tick();
    check_val("post_rst_in_ready", 32'(in_ready), 32'(1));

    // T1: all-zero stream
    n0 = n_emit;
    for (int i = 0; i < 24; i++) push_col(2'b00, 1'b1, 1'b0, 0, w);
    in_valid = 1'b0;
    lo = 0;
    while (!in_ready && lo < 100) begin
      tick();
      lo++;
    end
    check_val("t1_busy_len", 32'(lo), 32'(24));
    check_val("t1_ov_start", 32'(out_valid), 32'(1));
    ov = 0;
    while (out_valid && ov < 100) begin
      tick();
      ov++;
    end
    check_val("t1_ov_len", 32'(ov), 32'(12));
    check_val("t1_count", 32'(n_emit - n0), 32'(12));

    // T2 + T3: known path, columns held through TRACE
    reset_dut();
    n0 = n_emit;
    for (int i = 0; i < 48; i++) begin
      push_col(pat(i), 1'b0, 1'b0, 0, w);
      if (i >= 24) check_val("t3_wait", 32'(w), ((i % 12) == 0) ? 32'(24) : 32'(0));
    end
    idle(40);
    check_val("t2_count", 32'(n_emit - n0), 32'(36));

    // T4: six blocks with random input gaps across pointer wrap
    reset_dut();
    n0 = n_emit;
    for (int i = 0; i < 84; i++) push_col(pat(i), 1'b0, 1'b0, int'($urandom_range(0, 3)), w);
    idle(45);
    check_val("t4_count", 32'(n_emit - n0), 32'(72));

    // T5: reset at TRACE step k=5
    reset_dut();
    for (int i = 0; i < 24; i++) push_col(pat(i), 1'b0, 1'b0, 0, w);
    in_valid = 1'b0;
    repeat (5) tick();
    check_val("t5_mid_trace", 32'(in_ready), 32'(0));
    reset_dut();
    check_val("t5_in_ready", 32'(in_ready), 32'(1));
    check_val("t5_out_valid", 32'(out_valid), 32'(0));
    n0 = n_emit;
    for (int i = 0; i < 24; i++) push_col(pat(i), 1'b0, 1'b0, 0, w);
    check_val("t5_quiet", 32'(n_emit - n0), 32'(0));
    in_valid = 1'b0;
    lo = 0;
    while (!out_valid && lo < 100) begin
      tick();
      lo++;
    end
    check_val("t5_latency", 32'(lo), 32'(24));
    idle(20);
    check_val("t5_count", 32'(n_emit - n0), 32'(12));

    // T6: wrong start state, fully on-path survivor memory
    reset_dut();
    n0 = n_emit;
    for (int i = 0; i < 48; i++) push_col(pat(i), 1'b1, 1'b1, 0, w);
    idle(40);
    check_val("t6_count", 32'(n_emit - n0), 32'(36));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
